// File: rtl/axs_pkg.sv
// Shared types and constants for the axs slave-port channel FSMs.
package axs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } axs_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned FIFO_SEL_W = 2;

endpackage

// File: rtl/axs_beat_cnt.sv
// Burst beat counter: synchronous clear, increment per beat, compare against burst length.
module axs_beat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] len,
    output logic [W-1:0] cnt,
    output logic         at_len
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign at_len = (cnt_q == len);

endmodule

// File: rtl/axs_wr_fifo_fsm.sv
// AXI4 write responder for s0: one burst at a time, pushes beats into the selected input FIFO.
// Optional wlast checking is enabled with the AXS_WR_WLAST_CHECK_EN macro.
module axs_wr_fifo_fsm
    import axs_pkg::*;
#(
    parameter int unsigned ADDR_SEL_LSB = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            axs_s0_awid,
    input  logic [31:0]           axs_s0_awaddr,
    input  logic [7:0]            axs_s0_awlen,
    input  logic [2:0]            axs_s0_awsize,
    input  logic [1:0]            axs_s0_awburst,
    input  logic                  axs_s0_awvalid,
    output logic                  axs_s0_awready,
    input  logic                  axs_s0_wlast,
    input  logic                  axs_s0_wvalid,
    output logic                  axs_s0_wready,
    output logic [3:0]            axs_s0_bid,
    output logic [1:0]            axs_s0_bresp,
    output logic                  axs_s0_bvalid,
    input  logic                  axs_s0_bready,
    input  logic                  in_fifo_full,
    output logic                  in_fifo_push,
    output logic [FIFO_SEL_W-1:0] in_fifo_push_sel
);

    axs_state_e            state_q, state_d;
    logic                  awready_q, awready_d;
    logic [3:0]            id_q, id_d;
    logic [7:0]            len_q, len_d;
    logic [FIFO_SEL_W-1:0] sel_q, sel_d;

    logic       wready;
    logic       bvalid;
    logic       beat;
    logic       cnt_clr;
    logic       at_len;
    logic [7:0] beat_cnt;

    assign beat = axs_s0_wvalid & wready;

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        len_d   = len_q;
        sel_d   = sel_q;
        cnt_clr = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (state_q)
            IDLE: begin
                if (axs_s0_awvalid && awready_q) begin
                    id_d    = axs_s0_awid;
                    len_d   = axs_s0_awlen;
                    sel_d   = axs_s0_awaddr[ADDR_SEL_LSB +: FIFO_SEL_W];
                    cnt_clr = 1'b1;
                    state_d = DATA;
                end
            end
            DATA: begin
                wready = ~in_fifo_full;
                if (beat && at_len) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                bvalid = 1'b1;
                if (axs_s0_bready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // awready is registered off the next state so it is low in reset and rises one edge later
        awready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            awready_q <= 1'b0;
            id_q      <= '0;
            len_q     <= '0;
            sel_q     <= '0;
        end else begin
            state_q   <= state_d;
            awready_q <= awready_d;
            id_q      <= id_d;
            len_q     <= len_d;
            sel_q     <= sel_d;
        end
    end

    axs_beat_cnt #(.W(8)) u_beat_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (cnt_clr),
        .inc    (beat),
        .len    (len_q),
        .cnt    (beat_cnt),
        .at_len (at_len)
    );

`ifdef AXS_WR_WLAST_CHECK_EN
    logic err_q, err_d;

    // Sticky per burst; wlast never terminates the burst, only flags it
    always_comb begin
        err_d = err_q;
        if (state_q == IDLE) begin
            err_d = 1'b0;
        end else if (beat && (axs_s0_wlast != at_len)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign axs_s0_bresp = (bvalid && err_q) ? RESP_SLVERR : RESP_OKAY;

    logic unused_inputs;
    assign unused_inputs = ^{axs_s0_awsize, axs_s0_awburst, axs_s0_awaddr, beat_cnt};
`else
    assign axs_s0_bresp = RESP_OKAY;

    logic unused_inputs;
    assign unused_inputs = ^{axs_s0_awsize, axs_s0_awburst, axs_s0_awaddr, beat_cnt, axs_s0_wlast};
`endif

    assign axs_s0_awready   = awready_q;
    assign axs_s0_wready    = wready;
    assign axs_s0_bvalid    = bvalid;
    assign axs_s0_bid       = id_q;
    assign in_fifo_push     = beat;
    assign in_fifo_push_sel = sel_q;

endmodule
